// File: rtl/muldiv_unit_if.sv
// Handshake and write-back bundle between the core and muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic            wsig;
    logic [4:0]      wadd;
    logic [XLEN-1:0] wdata;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_addr,
        input  busy, done, wsig, wadd, wdata
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_addr,
        output busy, done, wsig, wadd, wdata
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier, restoring divider.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic [2:0]        op;
    logic [XLEN-1:0]   opa, opb;
    logic              sa, sb;
    logic [2*XLEN-1:0] acc;
    logic              done_q, wsig_q;
    logic [4:0]        wadd_q;
    logic [XLEN-1:0]   wdata_q;

    logic              in_sa, in_sb, in_div0, in_ovf, in_special;
    logic [XLEN-1:0]   in_a_abs, in_b_abs, in_special_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    logic [XLEN:0]     mul_sum, div_r, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN-1:0]   quo, rem, result;

    // Operand decode on the request inputs; resolves the single-cycle cases.
    always_comb begin
        in_sa    = bus.rs1_data[XLEN-1] &&
                   (bus.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
        in_sb    = bus.rs2_data[XLEN-1] &&
                   (bus.funct3 inside {3'd0, 3'd1, 3'd4, 3'd6});
        in_a_abs = in_sa ? -bus.rs1_data : bus.rs1_data;
        in_b_abs = in_sb ? -bus.rs2_data : bus.rs2_data;
        in_div0  = bus.funct3[2] && (bus.rs2_data == '0);
        in_ovf   = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
        in_special = in_div0 || in_ovf;
        if (in_div0)
            in_special_res = bus.funct3[1] ? bus.rs1_data : '1;
        else
            in_special_res = bus.funct3[1] ? '0 : MIN_NEG;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, in_a_abs} * {{XLEN{1'b0}}, in_b_abs};
        if (in_sa ^ in_sb)
            fast_prod = -fast_prod;
        if (!bus.funct3[2]) begin
            in_special     = 1'b1;
            in_special_res = (bus.funct3 == 3'd0) ? fast_prod[XLEN-1:0]
                                                  : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // acc: multiply keeps the running product; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (opb[0] ? {1'b0, opa} : '0);
        div_r    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_r - {1'b0, opb};
        div_ge   = (div_r >= {1'b0, opb});
        if (op[2])
            acc_nx = {div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0],
                      acc[XLEN-2:0], div_ge};
        else
            acc_nx = {mul_sum, acc[XLEN-1:1]};
    end

    always_comb begin
        prod = (sa ^ sb) ? -acc : acc;
        quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'd0:             result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result = quo;
            default:          result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = in_special ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The cycle after the 32nd iteration registers the sign-corrected result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            last    <= 1'b0;
            op      <= '0;
            opa     <= '0;
            opb     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            acc     <= '0;
            done_q  <= 1'b0;
            wsig_q  <= 1'b0;
            wadd_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    wsig_q <= 1'b0;
                    if (bus.start) begin
                        op     <= bus.funct3;
                        opa    <= in_a_abs;
                        opb    <= in_b_abs;
                        sa     <= in_sa;
                        sb     <= in_sb;
                        wadd_q <= bus.rd_addr;
                        cnt    <= '0;
                        last   <= 1'b0;
                        acc    <= bus.funct3[2] ? {{XLEN{1'b0}}, in_a_abs} : '0;
                        if (in_special) begin
                            wdata_q <= in_special_res;
                            done_q  <= 1'b1;
                            wsig_q  <= (bus.rd_addr != '0);
                        end
                    end
                end
                CALC: begin
                    if (!last) begin
                        acc <= acc_nx;
                        if (!op[2])
                            opb <= opb >> 1;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN - 1))
                            last <= 1'b1;
                    end else begin
                        wdata_q <= result;
                        done_q  <= 1'b1;
                        wsig_q  <= (wadd_q != '0);
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    wsig_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.wsig  = wsig_q;
    assign bus.wadd  = wadd_q;
    assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus hand-computed literals.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
    } exp_t;
    exp_t expq[$];
    exp_t e;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // RV32M result computed with plain 64-bit / native integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f inside {3'd0, 3'd1, 3'd2}) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f inside {3'd0, 3'd1}) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        if (f == 3'd0) return p[31:0];
        if (!f[2]) return p[63:32];
        if (b == 32'd0) return f[1] ? a : 32'hFFFFFFFF;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return f[1] ? 32'd0 : 32'h80000000;
        if (!f[0]) return f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return f[1] ? a % b : a / b;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 34;
    endfunction

    // Compare process: every write-back against the model queue; no stray writes.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.done) begin
                chk("done_busy", 32'(bus.busy), 32'd1);
                if (expq.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("model_wdata", bus.wdata, e.d);
                    chk("model_wadd", 32'(bus.wadd), 32'(e.rd));
                    chk("model_wsig", 32'(bus.wsig), 32'(e.rd != 5'd0));
                end
            end else begin
                chk("idle_wsig", 32'(bus.wsig), 32'd0);
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] lit, input bit poke);
        int          cyc;
        int          lat;
        bit          seen;
        logic [31:0] got;
        exp_t        x;
        lat = exp_lat(f, a, b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_addr  = rd;
        x.d  = model(f, a, b);
        x.rd = rd;
        expq.push_back(x);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_addr  = 5'($urandom);
        cyc  = 0;
        seen = 1'b0;
        got  = '0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (bus.done) begin
                got  = bus.wdata;
                seen = 1'b1;
                bus.start = poke;
            end else if (poke && cyc == 5) begin
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({name, "_lat"}, 32'(cyc), 32'(lat));
        chk({name, "_seen"}, 32'(seen), 32'd1);
        chk({name, "_lit"}, got, lit);
        chk({name, "_hold"}, bus.wdata, lit);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        bus.start    = 1'b0;
        bus.funct3   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_addr  = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wsig", 32'(bus.wsig), 32'd0);
        chk("rst_wadd", 32'(bus.wadd), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);

        run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFA, 5'd5,  32'hFFFFFFD6, 1'b1);
        run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 1'b0);
        run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 1'b0);
        run_op("mulhsu0", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd0,  32'hFFFFFFFF, 1'b0);
        run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 1'b0);
        run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0);
        run_op("divu0",   3'd5, 32'd9,        32'd0,        5'd10, 32'hFFFFFFFF, 1'b0);
        run_op("div0",    3'd4, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1'b0);
        run_op("rem0",    3'd6, 32'd5,        32'd0,        5'd12, 32'd5,        1'b1);
        run_op("divovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b0);
        run_op("removf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1'b0);
        run_op("divu",    3'd5, 32'd100,      32'd7,        5'd15, 32'd14,       1'b0);
        run_op("remu",    3'd7, 32'd100,      32'd7,        5'd16, 32'd2,        1'b0);

        // Abort a multiply partway through CALC.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = 3'd0;
        bus.rs1_data = 32'd3;
        bus.rs2_data = 32'd5;
        bus.rd_addr  = 5'd9;
        @(negedge clk);
        bus.start = 1'b0;
        chk("midop_busy", 32'(bus.busy), 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midop_rst_busy", 32'(bus.busy), 32'd0);
        chk("midop_rst_done", 32'(bus.done), 32'd0);
        chk("midop_rst_wsig", 32'(bus.wsig), 32'd0);
        chk("midop_rst_wadd", 32'(bus.wadd), 32'd0);
        chk("midop_rst_wdata", bus.wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.wsig) pulses++;
        end
        chk("midop_no_wb", 32'(pulses), 32'd0);

        run_op("div_after", 3'd4, 32'd20, 32'hFFFFFFFC, 5'd31, 32'hFFFFFFFB, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
